// File: rtl/apb_regfile_slave.sv
// APB3 completer holding a DEPTH x DATA_W register file with programmable wait states,
// per-register write protection and an error response on address/direction instability.
module apb_regfile_slave #(
  parameter int unsigned             ADDR_W      = 3,
  parameter int unsigned             DATA_W      = 8,
  parameter int unsigned             WAIT_STATES = 0,
  parameter logic [(2**ADDR_W)-1:0]  RO_MASK     = 8'h80,
  parameter logic [DATA_W-1:0]       RST_VAL     = '0
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              pselx,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic              pready,
  output logic              pslverr,
  output logic [DATA_W-1:0] prdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e              r_state;
  logic [3:0]          r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_dir;
  logic [DATA_W-1:0]   r_regs [DEPTH];

  logic                w_setup;
  logic                w_complete;
  logic                w_err;

  assign w_setup    = pselx && !penable;
  assign w_complete = (r_state == StAccess) && pselx && penable && (r_cnt == 4'd0);
  // Any change of address or direction after SETUP is treated as a protocol error.
  assign w_err      = (pwrite && RO_MASK[paddr]) || (paddr != r_addr) || (pwrite != r_dir);

  always_comb begin
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = '0;
    if (w_complete) begin
      pready  = 1'b1;
      pslverr = w_err;
      if (!w_err && !pwrite) begin
        prdata = r_regs[r_addr];
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_dir   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= RST_VAL;
      end
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_setup) begin
            r_state <= StAccess;
            r_cnt   <= 4'(WAIT_STATES);
            r_addr  <= paddr;
            r_dir   <= pwrite;
          end
        end
        StAccess: begin
          if (!pselx) begin
            r_state <= StIdle;
          end else if (!penable) begin
            r_cnt  <= 4'(WAIT_STATES);
            r_addr <= paddr;
            r_dir  <= pwrite;
          end else if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            if (pwrite && !w_err) begin
              r_regs[r_addr] <= pwdata;
            end
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Directed bench: three completers (0, 3 and 2 wait states) driven by independent APB buses.
module tb_apb_regfile_slave;

  logic       pclk = 1'b0;
  logic       rst  [3];
  logic       sel  [3];
  logic       en   [3];
  logic       wr   [3];
  logic [2:0] addr [3];
  logic [7:0] wd   [3];
  logic       rdy  [3];
  logic       err  [3];
  logic [7:0] rd   [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 pclk = ~pclk;

  apb_regfile_slave #(.WAIT_STATES(0)) u_w0 (
    .pclk(pclk), .preset(rst[0]), .pselx(sel[0]), .penable(en[0]), .pwrite(wr[0]),
    .paddr(addr[0]), .pwdata(wd[0]), .pready(rdy[0]), .pslverr(err[0]), .prdata(rd[0])
  );
  apb_regfile_slave #(.WAIT_STATES(3)) u_w3 (
    .pclk(pclk), .preset(rst[1]), .pselx(sel[1]), .penable(en[1]), .pwrite(wr[1]),
    .paddr(addr[1]), .pwdata(wd[1]), .pready(rdy[1]), .pslverr(err[1]), .prdata(rd[1])
  );
  apb_regfile_slave #(.WAIT_STATES(2)) u_w2 (
    .pclk(pclk), .preset(rst[2]), .pselx(sel[2]), .penable(en[2]), .pwrite(wr[2]),
    .paddr(addr[2]), .pwdata(wd[2]), .pready(rdy[2]), .pslverr(err[2]), .prdata(rd[2])
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic chk_idle(input int i, input string tag);
    chk({tag, " pready"}, 32'(rdy[i]), 32'd0);
    chk({tag, " pslverr"}, 32'(err[i]), 32'd0);
    chk({tag, " prdata"}, 32'(rd[i]), 32'd0);
  endtask

  task automatic setup(input int i, input logic w, input logic [2:0] a, input logic [7:0] d);
    @(posedge pclk);
    #1;
    sel[i] = 1'b1; en[i] = 1'b0; wr[i] = w; addr[i] = a; wd[i] = d;
    @(negedge pclk);
    chk("setup pready", 32'(rdy[i]), 32'd0);
    @(posedge pclk);
    #1;
    en[i] = 1'b1;
  endtask

  // Counts low-pready ACCESS cycles, bounded so a stuck DUT still reaches the summary.
  task automatic wait_ready(input int i, output int waits);
    waits = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge pclk);
      if (rdy[i]) break;
      waits++;
    end
  endtask

  task automatic release_bus(input int i);
    @(posedge pclk);
    #1;
    sel[i] = 1'b0; en[i] = 1'b0;
    @(negedge pclk);
    chk("post pready", 32'(rdy[i]), 32'd0);
  endtask

  task automatic xfer(input int i, input logic w, input logic [2:0] a, input logic [7:0] d,
                      input int exp_waits, input logic exp_err, input logic [7:0] exp_rd,
                      input string tag);
    int waits;
    setup(i, w, a, d);
    wait_ready(i, waits);
    chk({tag, " waits"}, 32'(waits), 32'(exp_waits));
    chk({tag, " pready"}, 32'(rdy[i]), 32'd1);
    chk({tag, " pslverr"}, 32'(err[i]), 32'(exp_err));
    chk({tag, " prdata"}, 32'(rd[i]), 32'(exp_rd));
    release_bus(i);
  endtask

  initial begin
    int waits;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; sel[i] = 1'b0; en[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wd[i] = '0;
    end
    repeat (3) @(posedge pclk);
    #1;
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    @(negedge pclk);
    for (int i = 0; i < 3; i++) chk_idle(i, "reset");

    // Zero wait states: write/read, protected register
    xfer(0, 1'b1, 3'd2, 8'h5A, 0, 1'b0, 8'h00, "w0 wr2");
    xfer(0, 1'b0, 3'd2, 8'h00, 0, 1'b0, 8'h5A, "w0 rd2");
    xfer(0, 1'b1, 3'd7, 8'hFF, 0, 1'b1, 8'h00, "w0 wr7 ro");
    xfer(0, 1'b0, 3'd7, 8'h00, 0, 1'b0, 8'h00, "w0 rd7");

    // penable without a SETUP phase must be ignored
    @(posedge pclk);
    #1;
    sel[0] = 1'b1; en[0] = 1'b1; wr[0] = 1'b0; addr[0] = 3'd2;
    repeat (2) begin
      @(negedge pclk);
      chk("no setup pready", 32'(rdy[0]), 32'd0);
    end
    release_bus(0);

    // Three wait states
    xfer(1, 1'b0, 3'd1, 8'h00, 3, 1'b0, 8'h00, "w3 rd1");

    // Address changes during the wait phase
    setup(1, 1'b1, 3'd3, 8'h11);
    @(negedge pclk);
    chk("addr chg wait", 32'(rdy[1]), 32'd0);
    @(posedge pclk);
    #1;
    addr[1] = 3'd4;
    wait_ready(1, waits);
    chk("addr chg waits", 32'(waits), 32'd2);
    chk("addr chg pready", 32'(rdy[1]), 32'd1);
    chk("addr chg pslverr", 32'(err[1]), 32'd1);
    release_bus(1);
    xfer(1, 1'b0, 3'd3, 8'h00, 3, 1'b0, 8'h00, "w3 rd3");
    xfer(1, 1'b0, 3'd4, 8'h00, 3, 1'b0, 8'h00, "w3 rd4");

    // Abort by dropping pselx mid-wait
    setup(2, 1'b1, 3'd5, 8'h77);
    @(negedge pclk);
    chk("abort wait", 32'(rdy[2]), 32'd0);
    @(posedge pclk);
    #1;
    sel[2] = 1'b0; en[2] = 1'b0;
    repeat (4) begin
      @(negedge pclk);
      chk("abort pready", 32'(rdy[2]), 32'd0);
    end
    xfer(2, 1'b0, 3'd5, 8'h00, 2, 1'b0, 8'h00, "w2 rd5 after abort");
    xfer(2, 1'b1, 3'd5, 8'h66, 2, 1'b0, 8'h00, "w2 wr5");
    xfer(2, 1'b0, 3'd5, 8'h00, 2, 1'b0, 8'h66, "w2 rd5");

    // Reset in the middle of a waited write
    xfer(1, 1'b1, 3'd0, 8'h33, 3, 1'b0, 8'h00, "w3 wr0");
    xfer(1, 1'b0, 3'd0, 8'h00, 3, 1'b0, 8'h33, "w3 rd0");
    setup(1, 1'b1, 3'd0, 8'h55);
    @(negedge pclk);
    chk("rst wait", 32'(rdy[1]), 32'd0);
    @(posedge pclk);
    #1;
    rst[1] = 1'b1;
    @(posedge pclk);
    #1;
    rst[1] = 1'b0; sel[1] = 1'b0; en[1] = 1'b0;
    @(negedge pclk);
    chk_idle(1, "after rst");
    xfer(1, 1'b0, 3'd0, 8'h00, 3, 1'b0, 8'h00, "w3 rd0 after rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
